// File: rtl/alu_seq_ctrl_if.sv
// Instruction handshake plus ALU / register-file control bundle for alu_seq_ctrl.
// Counter outputs exist only when ALU_SEQ_CTRL_PERF_EN is defined.
interface alu_seq_ctrl_if #(
    parameter int REG_AW  = 2,
    parameter int INSTR_W = 12
);
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic               instr_ready;
    logic               alu_Z;
    logic               alu_C;
    logic               alu_O;
    logic               alu_N;
    logic [1:0]         alu_op_sel;
    logic [3:0]         alu_opcode;
    logic [REG_AW-1:0]  rf_ra;
    logic [REG_AW-1:0]  rf_rb;
    logic [REG_AW-1:0]  rf_wa;
    logic               rf_we;
    logic [3:0]         flags_q;
    logic               done;
    logic               illegal;
`ifdef ALU_SEQ_CTRL_PERF_EN
    logic [15:0]        instr_cnt;
    logic [7:0]         illegal_cnt;
`endif

    modport master (
        input  instr_valid, instr, alu_Z, alu_C, alu_O, alu_N,
        output instr_ready, alu_op_sel, alu_opcode, rf_ra, rf_rb, rf_wa,
               rf_we, flags_q, done, illegal
`ifdef ALU_SEQ_CTRL_PERF_EN
        , output instr_cnt, illegal_cnt
`endif
    );

    modport slave (
        output instr_valid, instr, alu_Z, alu_C, alu_O, alu_N,
        input  instr_ready, alu_op_sel, alu_opcode, rf_ra, rf_rb, rf_wa,
               rf_we, flags_q, done, illegal
`ifdef ALU_SEQ_CTRL_PERF_EN
        , input instr_cnt, illegal_cnt
`endif
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequences one instruction through the ALU/register file; optional counters under ALU_SEQ_CTRL_PERF_EN.
// Latency: fixed 4 cycles from accept to the edge ending WB (done pulse in cycle 3).
// Backpressure: instr_ready high only in IDLE; no pipelining, one accept per 4 cycles at most.
module alu_seq_ctrl #(
    parameter int REG_AW  = 2,
    parameter int INSTR_W = 12
) (
    input  logic           clk,
    input  logic           rst,
    alu_seq_ctrl_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_DEC, S_EXEC, S_WB} state_t;
    typedef enum logic [1:0] {FL_KEEP, FL_LOGIC, FL_ALL} flag_mode_t;

    state_t            state;
    logic [3:0]        op_q;
    logic [REG_AW-1:0] rd_q, rs1_q, rs2_q;

    logic              instr_ready_q;
    logic [1:0]        op_sel_q;
    logic [3:0]        opcode_q;
    logic [REG_AW-1:0] ra_q, rb_q, wa_q;
    logic              rf_we_q, done_q, illegal_q;
    logic [3:0]        flags_q;

    logic [1:0]        dec_op_sel;
    logic [3:0]        dec_opcode;
    logic              dec_we;
    logic              dec_illegal;
    flag_mode_t        dec_flags;

    // Reserved instruction bits carry no meaning.
    logic unused_rsvd;
    assign unused_rsvd = ^bus.instr[1:0];

    always_comb begin
        dec_op_sel  = 2'b00;
        dec_opcode  = 4'h0;
        dec_we      = 1'b0;
        dec_illegal = 1'b0;
        dec_flags   = FL_KEEP;
        case (op_q)
            4'h0: ;
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                dec_op_sel = 2'b01;
                dec_opcode = op_q;
                dec_we     = 1'b1;
                dec_flags  = FL_LOGIC;
            end
            4'h8: begin
                dec_op_sel = 2'b10;
                dec_we     = 1'b1;
                dec_flags  = FL_ALL;
            end
            4'h9: begin
                dec_op_sel = 2'b11;
                dec_we     = 1'b1;
                dec_flags  = FL_ALL;
            end
            4'hA: begin
                dec_op_sel = 2'b11;
                dec_flags  = FL_ALL;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            op_q          <= 4'h0;
            rd_q          <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            instr_ready_q <= 1'b1;
            op_sel_q      <= 2'b00;
            opcode_q      <= 4'h0;
            ra_q          <= '0;
            rb_q          <= '0;
            wa_q          <= '0;
            rf_we_q       <= 1'b0;
            done_q        <= 1'b0;
            illegal_q     <= 1'b0;
            flags_q       <= 4'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.instr_valid && instr_ready_q) begin
                        op_q          <= bus.instr[11:8];
                        rd_q          <= bus.instr[7:6];
                        rs1_q         <= bus.instr[5:4];
                        rs2_q         <= bus.instr[3:2];
                        instr_ready_q <= 1'b0;
                        state         <= S_DEC;
                    end
                end
                S_DEC: begin
                    op_sel_q <= dec_op_sel;
                    opcode_q <= dec_opcode;
                    ra_q     <= rs1_q;
                    rb_q     <= rs2_q;
                    wa_q     <= rd_q;
                    state    <= S_EXEC;
                end
                S_EXEC: begin
                    rf_we_q   <= dec_we;
                    done_q    <= 1'b1;
                    illegal_q <= dec_illegal;
                    state     <= S_WB;
                end
                S_WB: begin
                    // ALU flags have settled by now; commit them as the write lands.
                    case (dec_flags)
                        FL_LOGIC: flags_q <= {bus.alu_N, 1'b0, 1'b0, bus.alu_Z};
                        FL_ALL:   flags_q <= {bus.alu_N, bus.alu_O, bus.alu_C, bus.alu_Z};
                        default:  flags_q <= flags_q;
                    endcase
                    rf_we_q       <= 1'b0;
                    done_q        <= 1'b0;
                    illegal_q     <= 1'b0;
                    op_sel_q      <= 2'b00;
                    opcode_q      <= 4'h0;
                    ra_q          <= '0;
                    rb_q          <= '0;
                    wa_q          <= '0;
                    instr_ready_q <= 1'b1;
                    state         <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.instr_ready = instr_ready_q;
    assign bus.alu_op_sel  = op_sel_q;
    assign bus.alu_opcode  = opcode_q;
    assign bus.rf_ra       = ra_q;
    assign bus.rf_rb       = rb_q;
    assign bus.rf_wa       = wa_q;
    assign bus.rf_we       = rf_we_q;
    assign bus.flags_q     = flags_q;
    assign bus.done        = done_q;
    assign bus.illegal     = illegal_q;

`ifdef ALU_SEQ_CTRL_PERF_EN
    logic [15:0] instr_cnt_q;
    logic [7:0]  illegal_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_cnt_q   <= 16'h0;
            illegal_cnt_q <= 8'h0;
        end else begin
            if (done_q && (instr_cnt_q != 16'hFFFF))
                instr_cnt_q <= instr_cnt_q + 16'h1;
            if (illegal_q && (illegal_cnt_q != 8'hFF))
                illegal_cnt_q <= illegal_cnt_q + 8'h1;
        end
    end

    assign bus.instr_cnt   = instr_cnt_q;
    assign bus.illegal_cnt = illegal_cnt_q;
`endif
endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Multi-cycle control sequencer for the 4-bit ALU and a 4-entry register file.
- Accepts one 12-bit instruction per valid/ready handshake, decodes it, drives ALU op_sel/opcode and register-file addresses, then commits the result and the ALU flags.
- Sits between the microcode/instruction source and the datapath (ALU, register file, flag register).

Parameters:
- REG_AW, 2, register-file address width; fixed instruction fields assume 2.
- INSTR_W, 12, instruction width; [11:8] op, [7:6] rd, [5:4] rs1, [3:2] rs2, [1:0] reserved (ignored).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- instr_valid  in  1  instruction present.
- instr  in  12  instruction word.
- instr_ready  out  1  controller can accept.
- alu_Z, alu_C, alu_O, alu_N  in  1 each  combinational ALU flags.
- alu_op_sel  out  2  00 idle, 01 logic, 10 add, 11 sub.
- alu_opcode  out  4  logic function select.
- rf_ra  out  2  operand A read address.
- rf_rb  out  2  operand B read address.
- rf_wa  out  2  write address.
- rf_we  out  1  register write enable (1-cycle pulse).
- flags_q  out  4  architectural flags {N,O,C,Z}.
- done  out  1  1-cycle completion pulse.
- illegal  out  1  1-cycle pulse, with done, for undefined op.

Behaviour:
- Reset: state=IDLE, instr_ready=1, all other outputs 0, flags_q=0. Reset mid-instruction abandons it, with no rf_we.
- States: IDLE -> DEC -> EXEC -> WB -> IDLE. Every instruction takes exactly 4 cycles from accept; no pipelining.
- IDLE:
  - instr_ready=1.
  - On instr_valid&instr_ready, latch instr and go to DEC.
  - instr ignored otherwise.
- DEC:
  - instr_ready=0.
  - Register rf_ra=rs1, rf_rb=rs2, rf_wa=rd, decoded alu_op_sel/alu_opcode, valid from the next cycle.
- EXEC: controls stable; ALU settles.
- WB:
  - Controls still stable.
  - rf_we=1 if op writes.
  - flags_q updated at the edge ending WB.
  - done=1.
  - Next state IDLE.
- Op decode:
  - 0x0 NOP: op_sel 00, no rf_we, flags unchanged.
  - 0x1–0x7 NOT/AND/OR/NAND/NOR/XOR/XNOR: op_sel 01, opcode=op, rf_we; Z,N from ALU; C,O cleared.
  - 0x8 ADD: op_sel 10, opcode 0, rf_we, all four flags from ALU.
  - 0x9 SUB: op_sel 11, rf_we, all flags.
  - 0xA CMP: op_sel 11, no rf_we, all flags.
  - 0xB–0xF: no rf_we, flags unchanged, illegal=1 in WB.
- Outputs:
  - alu_op_sel, alu_opcode and the address outputs return to 0 in IDLE.
  - rf_we, done and illegal are 0 outside WB.
- instr changing while not in IDLE has no effect.
- Back-to-back: instr_valid held high gives one accept every 4 cycles; instr_ready is high only in IDLE.
- rd equal to rs1/rs2 is legal. Read happens before the write edge.

Optional Feature:
- Macro ALU_SEQ_CTRL_PERF_EN.
- Enabled:
  - Adds outputs instr_cnt[15:0] (increments on each done) and illegal_cnt[7:0] (increments on each illegal).
  - Both counters are reset to 0 and saturate at all-ones.
- Disabled: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset mid-EXEC of ADD -> IDLE immediately, instr_ready=1, no rf_we, flags_q=0.
- instr 12'h86C (ADD r1=r2+r3), bench ALU with r2=7, r3=1:
  - op_sel 10 from cycle 2.
  - rf_we, done and rf_wa=1 at cycle 3.
  - r1=8; flags_q={N=1,O=1,C=0,Z=0}.
- instr 12'hA6C (CMP r2,r3) with r2=r3=5 -> no rf_we; flags_q Z=1, C=0 (no borrow), N=0, O=0; registers unchanged.
- instr 12'h26C (AND) with r2=4'hC, r3=4'h3 after ADD set C/O -> r1=0; flags_q={0,0,0,1}.
- instr 12'hF00 -> illegal and done pulse together in WB, no rf_we, flags_q unchanged; next instr accepted 4 cycles after the first.
- instr_valid held high with 3 queued instrs -> accepts at cycles 0, 4, 8; done at 3, 7, 11. With PERF_EN, instr_cnt=3.
